// File: rtl/mic_freq_classifier.sv
// mic_freq_classifier: synchronises and glitch-filters the raw mic comparator wave,
// counts its rising edges per gate window and classifies/debounces the count into a tone code.
// Optional build macro FREQ_HOLD_EN: dropping a nonzero tone to 0 needs one extra silent window.
module mic_freq_classifier #(
  parameter int WINDOW_CYCLES = 10_000_000,
  parameter int FILTER_LEN    = 4,
  parameter int F1            = 100,
  parameter int F2            = 200,
  parameter int F3            = 300,
  parameter int F4            = 500,
  parameter int TOL           = 5,
  parameter int CONFIRM       = 2
) (
  input  logic        RAW_clk,
  input  logic        RAW_reset,
  input  logic        RAW_Mic,
  output logic        MicFilt,
  output logic [15:0] EdgeCount,
  output logic        WinDone,
  output logic [3:0]  FreqState
);

  localparam int               WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

  typedef enum logic {TRACK, STABLE} state_t;

  // Input conditioning
  logic       sync1_q, sync2_q;
  logic       filt_q, filt_prev_q;
  logic [3:0] filt_cnt_q;

  // Edge counting and window timing
  logic [WIN_W-1:0] win_q;
  logic [15:0]      run_q, run_d;
  logic [15:0]      edge_cnt_q;
  logic             win_done_q;
  logic             rise;
  logic             win_last;

  // Classification and confirmation
  logic [3:0] cls;
  logic [3:0] cand_q, cand_d;
  logic [3:0] conf_q, conf_d;
  logic [3:0] thr;
  logic [3:0] freq_q;
  state_t     state_q;

  assign MicFilt   = filt_q;
  assign EdgeCount = edge_cnt_q;
  assign WinDone   = win_done_q;
  assign FreqState = freq_q;

  // True when cnt lies within +/-TOL of the bin centre f (32-bit math avoids underflow).
  function automatic logic in_bin(input logic [15:0] cnt, input int f);
    logic [31:0] c32;
    c32 = {16'd0, cnt};
    return ((c32 + 32'(TOL)) >= 32'(f)) && (c32 <= 32'(f + TOL));
  endfunction

  // Two-flop synchroniser, then a run-length filter: MicFilt flips only after
  // FILTER_LEN consecutive synced samples disagree with it.
  always_ff @(posedge RAW_clk) begin
    if (RAW_reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      filt_cnt_q  <= 4'd0;
    end else begin
      sync1_q     <= RAW_Mic;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      if (sync2_q != filt_q) begin
        if (filt_cnt_q == FLT_LAST) begin
          filt_q     <= sync2_q;
          filt_cnt_q <= 4'd0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 4'd1;
        end
      end else begin
        filt_cnt_q <= 4'd0;
      end
    end
  end

  assign rise     = filt_q & ~filt_prev_q;
  assign win_last = (win_q == WIN_LAST);

  // Running edge count including this cycle's edge, saturating at all-ones.
  always_comb begin
    run_d = run_q;
    if (rise && (run_q != 16'hFFFF)) begin
      run_d = run_q + 16'd1;
    end
  end

  // Free-running gate window; the closing cycle's edge is folded into the published count.
  always_ff @(posedge RAW_clk) begin
    if (RAW_reset) begin
      win_q      <= '0;
      run_q      <= 16'd0;
      edge_cnt_q <= 16'd0;
      win_done_q <= 1'b0;
    end else if (win_last) begin
      win_q      <= '0;
      run_q      <= 16'd0;
      edge_cnt_q <= run_d;
      win_done_q <= 1'b1;
    end else begin
      win_q      <= win_q + WIN_W'(1);
      run_q      <= run_d;
      win_done_q <= 1'b0;
    end
  end

  // Tone class from the published count; lowest matching bin wins, empty or saturated counts are no tone.
  always_comb begin
    cls = 4'd0;
    if ((edge_cnt_q == 16'd0) || (edge_cnt_q == 16'hFFFF)) begin
      cls = 4'd0;
    end else if (in_bin(edge_cnt_q, F1)) begin
      cls = 4'd1;
    end else if (in_bin(edge_cnt_q, F2)) begin
      cls = 4'd2;
    end else if (in_bin(edge_cnt_q, F3)) begin
      cls = 4'd3;
    end else if (in_bin(edge_cnt_q, F4)) begin
      cls = 4'd4;
    end
  end

  // Number of agreeing windows needed to commit the current class.
  always_comb begin
`ifdef FREQ_HOLD_EN
    thr = ((cls == 4'd0) && (freq_q != 4'd0)) ? 4'(CONFIRM + 1) : 4'(CONFIRM);
`else
    thr = 4'(CONFIRM);
`endif
  end

  // Candidate/confirm update for the window just published.
  always_comb begin
    cand_d = cand_q;
    conf_d = conf_q;
    if (win_done_q) begin
      if (cls != cand_q) begin
        cand_d = cls;
        conf_d = 4'd1;
      end else if ((state_q == STABLE) || (conf_q >= thr)) begin
        conf_d = thr;
      end else begin
        conf_d = conf_q + 4'd1;
      end
    end
  end

  // Confirmation FSM: commits the candidate to FreqState once enough windows agree.
  always_ff @(posedge RAW_clk) begin
    if (RAW_reset) begin
      state_q <= TRACK;
      cand_q  <= 4'd0;
      conf_q  <= 4'd0;
      freq_q  <= 4'd0;
    end else if (win_done_q) begin
      cand_q <= cand_d;
      conf_q <= conf_d;
      if (conf_d >= thr) begin
        state_q <= STABLE;
        freq_q  <= cand_d;
      end else begin
        state_q <= TRACK;
      end
    end
  end

endmodule

// File: tb/tb_mic_freq_classifier.sv
// Directed bench for mic_freq_classifier with a 1000-cycle window and small tone bins.
// The stimulus generator produces exactly tone_n rising edges per 1000 cycles, phase-locked to reset release.
module tb_mic_freq_classifier;

  logic        RAW_clk = 1'b0;
  logic        RAW_reset;
  logic        RAW_Mic;
  logic        MicFilt;
  logic [15:0] EdgeCount;
  logic        WinDone;
  logic [3:0]  FreqState;

  int n_checks = 0;
  int n_fail   = 0;
  int tone_n   = 0;
  bit glitch_en = 1'b0;
  int ph       = 0;

  mic_freq_classifier #(
    .WINDOW_CYCLES(1000), .FILTER_LEN(4), .F1(10), .F2(20), .F3(30), .F4(50),
    .TOL(1), .CONFIRM(2)
  ) dut (
    .RAW_clk(RAW_clk), .RAW_reset(RAW_reset), .RAW_Mic(RAW_Mic),
    .MicFilt(MicFilt), .EdgeCount(EdgeCount), .WinDone(WinDone), .FreqState(FreqState)
  );

  initial forever #5 RAW_clk = ~RAW_clk;

  // Mic level at window phase p: n rising edges per 1000 cycles, first one at p=0;
  // optional 3-cycle low glitch in the middle of each high phase of the 10-edge tone.
  function automatic logic mic_level(input int p, input int n, input bit g);
    if (n == 0) return 1'b0;
    if (g && (n == 10) && ((p % 100) >= 20) && ((p % 100) <= 22)) return 1'b0;
    return ((p * n) % 1000) < 500;
  endfunction

  // Generator: drives the mic on falling edges; phase restarts while reset is held.
  initial begin
    RAW_Mic = 1'b0;
    forever begin
      @(negedge RAW_clk);
      if (RAW_reset !== 1'b0) begin
        ph = 0;
        RAW_Mic = 1'b0;
      end else begin
        RAW_Mic = mic_level(ph, tone_n, glitch_en);
        ph = (ph + 1) % 1000;
      end
    end
  end

  task automatic tick();
    @(posedge RAW_clk);
    #2;
  endtask

  // Reset for two clocks; released right after a sample, so the next tick is window cycle 0.
  task automatic do_reset(input int n, input bit g);
    RAW_reset = 1'b1;
    tick();
    tick();
    tone_n    = n;
    glitch_en = g;
    RAW_reset = 1'b0;
  endtask

  task automatic test_reset();
    RAW_reset = 1'b1;
    tick();
    n_checks++; if (MicFilt !== 1'b0) begin n_fail++; $display("FAIL reset_micfilt: got %b want 0", MicFilt); end
    n_checks++; if (EdgeCount !== 16'd0) begin n_fail++; $display("FAIL reset_edgecount: got %0d want 0", EdgeCount); end
    n_checks++; if (WinDone !== 1'b0) begin n_fail++; $display("FAIL reset_windone: got %b want 0", WinDone); end
    n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL reset_freqstate: got %0d want 0", FreqState); end
    do_reset(0, 1'b0);
    for (int c = 0; c <= 3000; c++) begin
      logic exp_wd;
      tick();
      exp_wd = ((c + 1) % 1000 == 0);
      n_checks++; if (WinDone !== exp_wd) begin n_fail++; $display("FAIL silent_windone c=%0d: got %b want %b", c, WinDone, exp_wd); end
      if (exp_wd) begin
        n_checks++; if (EdgeCount !== 16'd0) begin n_fail++; $display("FAIL silent_edgecount c=%0d: got %0d want 0", c, EdgeCount); end
      end
    end
    n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL silent_freqstate: got %0d want 0", FreqState); end
  endtask

  task automatic test_tone1_glitch();
    do_reset(10, 1'b1);
    for (int c = 0; c <= 2000; c++) begin
      tick();
      if (c == 4) begin
        n_checks++; if (MicFilt !== 1'b0) begin n_fail++; $display("FAIL filt_latency_early: got %b want 0", MicFilt); end
      end
      if (c == 5 || (c >= 20 && c <= 30)) begin
        n_checks++; if (MicFilt !== 1'b1) begin n_fail++; $display("FAIL filt_level c=%0d: got %b want 1", c, MicFilt); end
      end
      if (c == 999 || c == 1999) begin
        n_checks++; if (EdgeCount !== 16'd10) begin n_fail++; $display("FAIL tone1_edgecount c=%0d: got %0d want 10", c, EdgeCount); end
      end
      if (c == 1000 || c == 1999) begin
        n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL tone1_unconfirmed c=%0d: got %0d want 0", c, FreqState); end
      end
      if (c == 2000) begin
        n_checks++; if (FreqState !== 4'd1) begin n_fail++; $display("FAIL tone1_confirmed: got %0d want 1", FreqState); end
      end
    end
  endtask

  task automatic test_tone_change();
    do_reset(10, 1'b0);
    for (int c = 0; c <= 5000; c++) begin
      tick();
      if ((c + 1) % 1000 == 0) begin
        int exp_ec;
        exp_ec = (c < 3000) ? 10 : 20;
        n_checks++; if (EdgeCount !== 16'(exp_ec)) begin n_fail++; $display("FAIL change_edgecount c=%0d: got %0d want %0d", c, EdgeCount, exp_ec); end
        if (c == 2999) tone_n = 20;
      end
      if (c == 2000 || c == 3000 || c == 4000) begin
        n_checks++; if (FreqState !== 4'd1) begin n_fail++; $display("FAIL change_hold1 c=%0d: got %0d want 1", c, FreqState); end
      end
      if (c == 5000) begin
        n_checks++; if (FreqState !== 4'd2) begin n_fail++; $display("FAIL change_to2: got %0d want 2", FreqState); end
      end
    end
  endtask

  task automatic test_back_to_back_alternate();
    do_reset(10, 1'b0);
    for (int c = 0; c <= 6000; c++) begin
      tick();
      if ((c + 1) % 1000 == 0) begin
        int m;
        int exp_ec;
        m = (c + 1) / 1000;
        exp_ec = (m % 2 == 1) ? 10 : 20;
        n_checks++; if (EdgeCount !== 16'(exp_ec)) begin n_fail++; $display("FAIL alt_edgecount c=%0d: got %0d want %0d", c, EdgeCount, exp_ec); end
        tone_n = (m % 2 == 1) ? 20 : 10;
      end
      if (c > 0 && c % 1000 == 0) begin
        n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL alt_freqstate c=%0d: got %0d want 0", c, FreqState); end
      end
    end
  endtask

  task automatic test_between_bins();
    do_reset(35, 1'b0);
    for (int c = 0; c <= 3000; c++) begin
      tick();
      if ((c + 1) % 1000 == 0) begin
        n_checks++; if (EdgeCount !== 16'd35) begin n_fail++; $display("FAIL gap_edgecount c=%0d: got %0d want 35", c, EdgeCount); end
      end
      if (c > 0 && c % 1000 == 0) begin
        n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL gap_freqstate c=%0d: got %0d want 0", c, FreqState); end
      end
    end
  endtask

  task automatic test_reset_mid_window();
    do_reset(20, 1'b0);
    for (int c = 0; c <= 2400; c++) begin
      tick();
      if (c == 1999) begin
        n_checks++; if (EdgeCount !== 16'd20) begin n_fail++; $display("FAIL mid_pre_edgecount: got %0d want 20", EdgeCount); end
      end
      if (c == 2000) begin
        n_checks++; if (FreqState !== 4'd2) begin n_fail++; $display("FAIL mid_pre_freqstate: got %0d want 2", FreqState); end
      end
    end
    RAW_reset = 1'b1;
    tick();
    n_checks++; if (EdgeCount !== 16'd0) begin n_fail++; $display("FAIL mid_rst_edgecount: got %0d want 0", EdgeCount); end
    n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL mid_rst_freqstate: got %0d want 0", FreqState); end
    n_checks++; if (MicFilt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_micfilt: got %b want 0", MicFilt); end
    n_checks++; if (WinDone !== 1'b0) begin n_fail++; $display("FAIL mid_rst_windone: got %b want 0", WinDone); end
    RAW_reset = 1'b0;
    for (int c = 0; c <= 1000; c++) begin
      logic exp_wd;
      tick();
      exp_wd = (c == 999);
      n_checks++; if (WinDone !== exp_wd) begin n_fail++; $display("FAIL mid_post_windone c=%0d: got %b want %b", c, WinDone, exp_wd); end
      if (c == 999) begin
        n_checks++; if (EdgeCount !== 16'd20) begin n_fail++; $display("FAIL mid_post_edgecount: got %0d want 20", EdgeCount); end
      end
    end
  endtask

  task automatic test_dropout();
    logic [3:0] exp_4000;
`ifdef FREQ_HOLD_EN
    exp_4000 = 4'd1;
`else
    exp_4000 = 4'd0;
`endif
    do_reset(10, 1'b0);
    for (int c = 0; c <= 5000; c++) begin
      tick();
      if (c == 999 || c == 1999) begin
        n_checks++; if (EdgeCount !== 16'd10) begin n_fail++; $display("FAIL drop_tone_edgecount c=%0d: got %0d want 10", c, EdgeCount); end
      end
      if (c == 1999) tone_n = 0;
      if (c == 2999 || c == 3999) begin
        n_checks++; if (EdgeCount !== 16'd0) begin n_fail++; $display("FAIL drop_silent_edgecount c=%0d: got %0d want 0", c, EdgeCount); end
      end
      if (c == 2000 || c == 3000) begin
        n_checks++; if (FreqState !== 4'd1) begin n_fail++; $display("FAIL drop_hold c=%0d: got %0d want 1", c, FreqState); end
      end
      if (c == 4000) begin
        n_checks++; if (FreqState !== exp_4000) begin n_fail++; $display("FAIL drop_second_silent: got %0d want %0d", FreqState, exp_4000); end
      end
      if (c == 5000) begin
        n_checks++; if (FreqState !== 4'd0) begin n_fail++; $display("FAIL drop_third_silent: got %0d want 0", FreqState); end
      end
    end
  endtask

  initial begin
    RAW_reset = 1'b1;
    test_reset();
    test_tone1_glitch();
    test_tone_change();
    test_back_to_back_alternate();
    test_between_bins();
    test_reset_mid_window();
    test_dropout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
